div_hilo_ctrl: RTL and testbench



---
 rtl/div_hilo_pkg.sv | 16 +
 rtl/div_hilo_ctrl.sv | 138 +++++++++++++
 tb/tb_div_hilo_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_hilo_pkg.sv
// rtl/div_hilo_pkg.sv - opcodes and state encoding shared with the control unit decoder
package div_hilo_pkg;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_MTHI = 2'd2;
  localparam logic [1:0] OP_MTLO = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/div_hilo_ctrl.sv
// rtl/div_hilo_ctrl.sv - divider sequencer and HI/LO register owner
module div_hilo_ctrl
  import div_hilo_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40,
  parameter int TCNTW   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_kill,
  output logic             op_done,
  output logic             stall,
  output logic             err_timeout,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             div_signed,
  output logic             div_start,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               sgn_q, sgn_d;
  logic               err_q, err_d;
  logic               seen_q, seen_d;
  logic [TCNTW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      seen_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    err_d   = err_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          a_d   = op_a;
          b_d   = op_b;
          sgn_d = (op_code == OP_DIV);
          err_d = 1'b0;
          case (op_code)
            OP_MTHI: begin
              hi_d    = op_a;
              state_d = ST_DONE;
            end
            OP_MTLO: begin
              lo_d    = op_a;
              state_d = ST_DONE;
            end
            default: begin
              // Divide by zero never reaches the divider: LO saturates, HI keeps the dividend.
              if (op_b == '0) begin
                lo_d    = '1;
                hi_d    = op_a;
                state_d = ST_DONE;
              end else begin
                state_d = ST_ISSUE;
              end
            end
          endcase
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        seen_d  = 1'b0;
        state_d = op_kill ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (div_busy) seen_d = 1'b1;
        // Kill beats writeback, writeback beats the watchdog.
        if (op_kill) begin
          state_d = ST_IDLE;
        end else if (seen_q && !div_busy) begin
          lo_d    = div_q;
          hi_d    = div_r;
          state_d = ST_DONE;
        end else if (cnt_q == TCNTW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign op_ready     = (state_q == ST_IDLE);
  assign stall        = !op_ready;
  assign op_done      = (state_q == ST_DONE);
  assign div_start    = (state_q == ST_ISSUE) && !op_kill;
  assign err_timeout  = err_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign div_dividend = a_q;
  assign div_divisor  = b_q;
  assign div_signed   = sgn_q;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// tb/tb_div_hilo_ctrl.sv - self-checking bench with a behavioural 32-cycle divider
module tb_div_hilo_ctrl;
  import div_hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_ready, op_kill, op_done, stall, err_timeout;
  logic [1:0]  op_code;
  logic [31:0] op_a, op_b, hi, lo, div_dividend, div_divisor, div_q, div_r;
  logic        div_signed, div_start, div_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_hilo_ctrl #(.WIDTH(32), .TIMEOUT(40), .TCNTW(6)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .op_kill(op_kill), .op_done(op_done), .stall(stall),
    .err_timeout(err_timeout), .hi(hi), .lo(lo), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_signed(div_signed), .div_start(div_start),
    .div_busy(div_busy), .div_q(div_q), .div_r(div_r)
  );

  // Reference arithmetic: truncating division, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Divider model: busy for 32 cycles after the start edge, start reloads it, stuck pins busy high.
  int unsigned bcnt;
  bit          stuck = 1'b0;
  logic [63:0] dres;
  always @(posedge clk or posedge rst) begin
    if (rst) bcnt <= 0;
    else if (div_start) bcnt <= 32;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign div_busy = stuck || (bcnt != 0);
  assign dres     = ref_div(div_signed, div_dividend, div_divisor);
  assign div_q    = dres[31:0];
  assign div_r    = dres[63:32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] elo, input logic [31:0] ehi, input string nm);
    int n, done_at, starts, start_at;
    bit held_ok, stall_ok;
    chk({nm, " ready"}, 32'(op_ready), 32'd1);
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
    step();
    op_valid = 1'b0; op_a = $urandom; op_b = $urandom;
    n = 1; done_at = -1; starts = 0; start_at = -1; held_ok = 1'b1; stall_ok = 1'b1;
    while (n <= 60 && done_at < 0) begin
      if (div_start) begin starts++; start_at = n; end
      if (!stall) stall_ok = 1'b0;
      if (div_dividend !== a || div_divisor !== b || div_signed !== (code == OP_DIV)) held_ok = 1'b0;
      if (op_done) done_at = n;
      else begin step(); n++; end
    end
    chk({nm, " done_cycle"}, 32'(done_at), 32'(lat));
    chk({nm, " starts"}, 32'(starts), (lat > 1) ? 32'd1 : 32'd0);
    if (lat > 1) chk({nm, " start_cycle"}, 32'(start_at), 32'd1);
    chk({nm, " held"}, 32'(held_ok), 32'd1);
    chk({nm, " stall"}, 32'(stall_ok), 32'd1);
    chk({nm, " lo"}, lo, elo);
    chk({nm, " hi"}, hi, ehi);
    step();
    chk({nm, " ready_after"}, 32'(op_ready), 32'd1);
    chk({nm, " done_pulse"}, 32'(op_done), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  code;
    logic [31:0] a, b;
    int          lat;
    logic [31:0] lo, hi;
  } vec_t;

  vec_t tbl[8];
  logic [31:0] exp_hi, exp_lo, hb, lb;
  logic [63:0] m;
  int n;
  bit saw_done;

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_kill = 1'b0; op_code = 2'd0; op_a = 32'd0; op_b = 32'd0;
    tbl[0] = '{OP_DIVU, 32'd100,        32'd7,          35, 32'd14,         32'd2};
    tbl[1] = '{OP_DIV,  32'hFFFFFFF9,   32'd2,          35, 32'hFFFFFFFD,   32'hFFFFFFFF};
    tbl[2] = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   35, 32'h80000000,   32'd0};
    tbl[3] = '{OP_DIVU, 32'd5,          32'd0,          1,  32'hFFFFFFFF,   32'd5};
    tbl[4] = '{OP_MTHI, 32'hDEADBEEF,   32'd0,          1,  32'hFFFFFFFF,   32'hDEADBEEF};
    tbl[5] = '{OP_MTLO, 32'h12345678,   32'd0,          1,  32'h12345678,   32'hDEADBEEF};
    tbl[6] = '{OP_DIV,  32'd7,          32'd0,          1,  32'hFFFFFFFF,   32'd7};
    tbl[7] = '{OP_DIV,  32'hFFFFFF9C,   32'd7,          35, 32'hFFFFFFF2,   32'hFFFFFFFE};

    repeat (3) @(posedge clk);
    #1;
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst ready", 32'(op_ready), 32'd1);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst done", 32'(op_done), 32'd0);
    chk("rst start", 32'(div_start), 32'd0);
    chk("rst err", 32'(err_timeout), 32'd0);
    chk("rst signed", 32'(div_signed), 32'd0);
    chk("rst operands", div_dividend | div_divisor, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].code, tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].lo, tbl[i].hi, $sformatf("vec%0d", i));
    exp_lo = tbl[7].lo; exp_hi = tbl[7].hi;

    // op_valid held during DONE must not be accepted.
    op_valid = 1'b1; op_code = OP_MTHI; op_a = 32'hCAFE0001;
    step();
    op_code = OP_MTLO; op_a = 32'h00000055;
    chk("ign done", 32'(op_done), 32'd1);
    step();
    op_valid = 1'b0;
    chk("ign ready", 32'(op_ready), 32'd1);
    step();
    chk("ign no_done", 32'(op_done), 32'd0);
    chk("ign lo", lo, exp_lo);
    chk("ign hi", hi, 32'hCAFE0001);
    exp_hi = 32'hCAFE0001;

    // Kill in ISSUE suppresses the start pulse.
    op_valid = 1'b1; op_code = OP_DIVU; op_a = 32'd10; op_b = 32'd2;
    step();
    op_valid = 1'b0;
    op_kill = 1'b1;
    #1;
    chk("kiss start", 32'(div_start), 32'd0);
    step();
    op_kill = 1'b0;
    chk("kiss ready", 32'(op_ready), 32'd1);
    step();
    chk("kiss done", 32'(op_done), 32'd0);
    chk("kiss lo", lo, exp_lo);
    chk("kiss hi", hi, exp_hi);

    // Kill mid-WAIT, then an immediate new divide.
    op_valid = 1'b1; op_code = OP_DIVU; op_a = 32'd1000; op_b = 32'd3;
    step();
    op_valid = 1'b0;
    saw_done = 1'b0;
    for (n = 1; n < 10; n++) begin
      if (op_done) saw_done = 1'b1;
      step();
    end
    op_kill = 1'b1;
    step();
    op_kill = 1'b0;
    chk("kill ready", 32'(op_ready), 32'd1);
    chk("kill no_done", 32'(saw_done | op_done), 32'd0);
    chk("kill lo", lo, exp_lo);
    chk("kill hi", hi, exp_hi);
    run_op(OP_DIVU, 32'd9, 32'd3, 35, 32'd3, 32'd0, "after_kill");
    exp_lo = 32'd3; exp_hi = 32'd0;

    // Stuck divider trips the watchdog after 40 WAIT cycles.
    stuck = 1'b1;
    op_valid = 1'b1; op_code = OP_DIVU; op_a = 32'd50; op_b = 32'd5;
    step();
    op_valid = 1'b0;
    saw_done = 1'b0;
    for (n = 1; n < 41; n++) begin
      if (op_done) saw_done = 1'b1;
      step();
    end
    chk("wd err_early", 32'(err_timeout), 32'd0);
    chk("wd stall_early", 32'(stall), 32'd1);
    step();
    chk("wd err", 32'(err_timeout), 32'd1);
    chk("wd ready", 32'(op_ready), 32'd1);
    chk("wd no_done", 32'(saw_done | op_done), 32'd0);
    chk("wd lo", lo, exp_lo);
    chk("wd hi", hi, exp_hi);
    stuck = 1'b0;
    run_op(OP_MTLO, 32'h000000A5, 32'd0, 1, 32'h000000A5, exp_hi, "clr_err");
    chk("wd err_clear", 32'(err_timeout), 32'd0);
    exp_lo = 32'h000000A5;

    // Randomised operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  c;
      logic [31:0] a, b;
      int lat;
      c = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(1, 300)));
      lat = 1;
      case (c)
        OP_MTHI: exp_hi = a;
        OP_MTLO: exp_lo = a;
        default: begin
          if (b == 32'd0) begin
            exp_lo = 32'hFFFFFFFF; exp_hi = a;
          end else begin
            m = ref_div(c == OP_DIV, a, b);
            exp_lo = m[31:0]; exp_hi = m[63:32]; lat = 35;
          end
        end
      endcase
      run_op(c, a, b, lat, exp_lo, exp_hi, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of WAIT.
    op_valid = 1'b1; op_code = OP_DIV; op_a = 32'd77; op_b = 32'd7;
    step();
    op_valid = 1'b0;
    repeat (10) step();
    #2 rst = 1'b1;
    #1;
    chk("arst hi", hi, 32'd0);
    chk("arst lo", lo, 32'd0);
    chk("arst ready", 32'(op_ready), 32'd1);
    chk("arst start_done", 32'({div_start, op_done}), 32'd0);
    chk("arst err_sign", 32'({err_timeout, div_signed}), 32'd0);
    chk("arst operands", div_dividend | div_divisor, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("arst idle", 32'(op_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
